// File: rtl/sm_ctrl_pkg.sv
// Shared types and constants for the schoolMIPS board run/step controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm_ctrl_pkg;

  // Controller FSM encoding; 2'd3 is unused and recovers to S_HALT
  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  // Register file size and the address width needed to reach every entry
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = $clog2(REG_COUNT);

  // Next register visited by the auto-scan; anything at or past last wraps to 0
  function automatic logic [REG_AW-1:0] next_reg(input logic [REG_AW-1:0] cur,
                                                 input logic [REG_AW-1:0] last);
    return (cur >= last) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/sm_debounce.sv
// Key synchroniser + debouncer emitting a one-cycle pulse on each debounced press.
// Latency: 2 sync cycles + 2^DEBOUNCE_W stable cycles; the pulse is registered.
// Backpressure: none; presses arriving while the consumer is busy are simply dropped by it.
module sm_debounce #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic clkIn,
  input  logic rst_n,
  input  logic key_n,
  output logic fall_pulse
);

  logic                  sync1;
  logic                  sync2;
  logic                  key_db;
  logic [DEBOUNCE_W-1:0] cnt;

  // Two-flop synchroniser; idles at the released (high) level
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has disagreed for 2^DEBOUNCE_W cycles in a row
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      key_db     <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      fall_pulse <= 1'b0;
      if (sync2 == key_db) begin
        cnt <= '0;
      end else if (&cnt) begin
        cnt        <= '0;
        key_db     <= sync2;
        fall_pulse <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm_run_ctrl.sv
// Board run/step controller: CPU clock-enable (halt/run/single-step), debug reg address, cycle count.
// Latency: one cycle from decision to registered output; step press adds debounce delay.
// Backpressure: none; step presses during RUN or an in-flight step are ignored.
module sm_run_ctrl
  import sm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_W = 16,
  parameter int SCAN_W     = 24,
  parameter int REG_LAST   = 31
) (
  input  logic              clkIn,
  input  logic              rst_n,
  input  logic              key_step_n,
  input  logic              run,
  input  logic              scan_en,
  input  logic [REG_AW-1:0] regSel,
  input  logic              cpuClk,
  output logic              clkEnable,
  output logic [REG_AW-1:0] regAddr,
  output logic              stepBusy,
  output logic              running,
  output logic [15:0]       cycleCount
);

  localparam logic [REG_AW-1:0] REG_LAST_A = REG_AW'(REG_LAST);

  state_t            state;
  logic              step_pulse;
  logic              cpu_clk_d;
  logic              cpu_rise;
  logic [SCAN_W-1:0] dwell;

  sm_debounce #(
    .DEBOUNCE_W(DEBOUNCE_W)
  ) u_key_step (
    .clkIn     (clkIn),
    .rst_n     (rst_n),
    .key_n     (key_step_n),
    .fall_pulse(step_pulse)
  );

  assign cpu_rise = cpuClk & ~cpu_clk_d;

  // Run/step FSM; outputs are loaded together with the state they belong to
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HALT;
      clkEnable <= 1'b0;
      running   <= 1'b0;
      stepBusy  <= 1'b0;
    end else begin
      case (state)
        S_HALT: begin
          if (run) begin
            state     <= S_RUN;
            clkEnable <= 1'b1;
            running   <= 1'b1;
            stepBusy  <= 1'b0;
          end else if (step_pulse) begin
            state     <= S_STEP;
            clkEnable <= 1'b1;
            running   <= 1'b0;
            stepBusy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!run) begin
            state     <= S_HALT;
            clkEnable <= 1'b0;
            running   <= 1'b0;
            stepBusy  <= 1'b0;
          end
        end
        S_STEP: begin
          // Finish the single CPU edge even if run rises; RUN follows via HALT
          if (cpu_rise) begin
            state     <= S_HALT;
            clkEnable <= 1'b0;
            running   <= 1'b0;
            stepBusy  <= 1'b0;
          end
        end
        default: begin
          state     <= S_HALT;
          clkEnable <= 1'b0;
          running   <= 1'b0;
          stepBusy  <= 1'b0;
        end
      endcase
    end
  end

  // CPU clock edge detector and free-running, wrapping edge counter
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      cpu_clk_d  <= 1'b0;
      cycleCount <= '0;
    end else begin
      cpu_clk_d <= cpuClk;
      if (cpu_rise) begin
        cycleCount <= cycleCount + 16'd1;
      end
    end
  end

  // Debug register address: follow the switches, or step through registers on each dwell wrap
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      regAddr <= '0;
      dwell   <= '0;
    end else if (!scan_en) begin
      regAddr <= regSel;
      dwell   <= '0;
    end else begin
      dwell <= dwell + 1'b1;
      if (&dwell) begin
        regAddr <= next_reg(regAddr, REG_LAST_A);
      end
    end
  end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl: vector table, hand-written corner sequences,
// and randomized stimulus compared every cycle against a behavioural model.
module tb_sm_run_ctrl;

  localparam int DW      = 4;
  localparam int SW      = 3;
  localparam int DB_LEN  = 1 << DW;  // consecutive disagreeing cycles before a key level is accepted
  localparam int SCAN_N  = 1 << SW;  // cycles each register is displayed
  localparam int LASTREG = 31;

  logic        clkIn = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_step_n = 1'b1;
  logic        run = 1'b0;
  logic        scan_en = 1'b0;
  logic [4:0]  regSel = 5'd0;
  logic        cpuClk = 1'b0;
  logic        clkEnable;
  logic [4:0]  regAddr;
  logic        stepBusy;
  logic        running;
  logic [15:0] cycleCount;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  sm_run_ctrl #(
    .DEBOUNCE_W(DW),
    .SCAN_W    (SW),
    .REG_LAST  (LASTREG)
  ) dut (
    .clkIn     (clkIn),
    .rst_n     (rst_n),
    .key_step_n(key_step_n),
    .run       (run),
    .scan_en   (scan_en),
    .regSel    (regSel),
    .cpuClk    (cpuClk),
    .clkEnable (clkEnable),
    .regAddr   (regAddr),
    .stepBusy  (stepBusy),
    .running   (running),
    .cycleCount(cycleCount)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment: sm_top-style divider, cpuClk toggles every 4 enabled clkIn cycles
  int div = 0;
  always @(negedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      div    = 0;
      cpuClk = 1'b0;
    end else if (clkEnable) begin
      div = div + 1;
      if (div == 4) begin
        div    = 0;
        cpuClk = ~cpuClk;
      end
    end
  end

  // Behavioural model
  localparam int MODE_IDLE = 0, MODE_FREE = 1, MODE_ONE = 2;
  int m_mode, m_mis, m_dwell, m_reg, m_cc;
  bit m_s1, m_s2, m_db, m_db_prev, m_cpu_d;
  bit press, edge_seen;

  always @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = MODE_IDLE; m_mis = 0; m_dwell = 0; m_reg = 0; m_cc = 0;
      m_s1 = 1; m_s2 = 1; m_db = 1; m_db_prev = 1; m_cpu_d = 0;
    end else begin
      press     = m_db_prev && !m_db;     // debounced level went released -> pressed
      edge_seen = cpuClk && !m_cpu_d;
      case (m_mode)
        MODE_IDLE: if (run) m_mode = MODE_FREE; else if (press) m_mode = MODE_ONE;
        MODE_FREE: if (!run) m_mode = MODE_IDLE;
        default:   if (edge_seen) m_mode = MODE_IDLE;
      endcase
      if (edge_seen) m_cc = (m_cc + 1) % 65536;
      if (!scan_en) begin
        m_reg = regSel; m_dwell = 0;
      end else begin
        m_dwell++;
        if (m_dwell == SCAN_N) begin
          m_dwell = 0;
          m_reg = (m_reg >= LASTREG) ? 0 : m_reg + 1;
        end
      end
      m_db_prev = m_db;
      if (m_s2 == m_db) m_mis = 0;
      else begin
        m_mis++;
        if (m_mis == DB_LEN) begin m_db = m_s2; m_mis = 0; end
      end
      m_s2 = m_s1; m_s1 = key_step_n;
      m_cpu_d = cpuClk;
    end
  end

  always @(negedge clkIn) begin
    if (chk_en && rst_n) begin
      check("mdl_clkEnable", clkEnable, m_mode != MODE_IDLE);
      check("mdl_running", running, m_mode == MODE_FREE);
      check("mdl_stepBusy", stepBusy, m_mode == MODE_ONE);
      check("mdl_regAddr", regAddr, m_reg);
      check("mdl_cycleCount", cycleCount, m_cc);
    end
  end

  typedef struct {
    logic       run;
    logic       scan;
    logic [4:0] sel;
    int         cycles;
    logic       e_en;
    logic       e_run;
    logic       e_busy;
    logic [4:0] e_reg;
  } vec_t;
  vec_t vecs[14];

  int n, saw, dlt;
  logic [15:0] cc0;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 5'd5,  1, 1'b0, 1'b0, 1'b0, 5'd5};
    vecs[1]  = '{1'b1, 1'b0, 5'd17, 1, 1'b1, 1'b1, 1'b0, 5'd17};
    vecs[2]  = '{1'b1, 1'b0, 5'd31, 3, 1'b1, 1'b1, 1'b0, 5'd31};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[4]  = '{1'b0, 1'b0, 5'd30, 2, 1'b0, 1'b0, 1'b0, 5'd30};
    vecs[5]  = '{1'b0, 1'b1, 5'd30, 7, 1'b0, 1'b0, 1'b0, 5'd30};
    vecs[6]  = '{1'b0, 1'b1, 5'd30, 1, 1'b0, 1'b0, 1'b0, 5'd31};
    vecs[7]  = '{1'b0, 1'b1, 5'd30, 7, 1'b0, 1'b0, 1'b0, 5'd31};
    vecs[8]  = '{1'b0, 1'b1, 5'd30, 1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[9]  = '{1'b0, 1'b1, 5'd12, 4, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[10] = '{1'b0, 1'b0, 5'd30, 1, 1'b0, 1'b0, 1'b0, 5'd30};
    vecs[11] = '{1'b0, 1'b1, 5'd30, 8, 1'b0, 1'b0, 1'b0, 5'd31};
    vecs[12] = '{1'b1, 1'b1, 5'd3,  9, 1'b1, 1'b1, 1'b0, 5'd0};
    vecs[13] = '{1'b0, 1'b0, 5'd9,  1, 1'b0, 1'b0, 1'b0, 5'd9};

    // Reset state
    repeat (3) @(negedge clkIn);
    check("rst_clkEnable", clkEnable, 0);
    check("rst_running", running, 0);
    check("rst_stepBusy", stepBusy, 0);
    check("rst_regAddr", regAddr, 0);
    check("rst_cycleCount", cycleCount, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clkIn);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      run = vecs[i].run; scan_en = vecs[i].scan; regSel = vecs[i].sel;
      repeat (vecs[i].cycles) @(posedge clkIn);
      @(negedge clkIn);
      check($sformatf("vec%0d_clkEnable", i), clkEnable, vecs[i].e_en);
      check($sformatf("vec%0d_running", i), running, vecs[i].e_run);
      check($sformatf("vec%0d_stepBusy", i), stepBusy, vecs[i].e_busy);
      check($sformatf("vec%0d_regAddr", i), regAddr, vecs[i].e_reg);
    end
    repeat (10) @(negedge clkIn);

    // Short bounce must not produce a step
    key_step_n = 1'b0;
    repeat (10) @(negedge clkIn);
    key_step_n = 1'b1;
    saw = 0;
    repeat (30) begin @(negedge clkIn); if (clkEnable) saw = 1; end
    check("bounce_no_step", saw, 0);

    // Held press gives exactly one CPU edge
    cc0 = 16'(m_cc);
    key_step_n = 1'b0;
    n = 0;
    while (!clkEnable && n < 40) begin @(negedge clkIn); n++; end
    check("step_start_en", clkEnable, 1);
    check("step_start_busy", stepBusy, 1);
    check("step_start_running", running, 0);
    n = 0;
    while (clkEnable && n < 50) begin @(negedge clkIn); n++; end
    check("step_window_len_ok", (n >= 1 && n <= 9), 1);
    check("step_end_en", clkEnable, 0);
    check("step_end_busy", stepBusy, 0);
    check("step_one_edge", cycleCount, cc0 + 16'd1);
    repeat (20) @(negedge clkIn);
    key_step_n = 1'b1;
    saw = 0;
    repeat (30) begin @(negedge clkIn); if (clkEnable) saw = 1; end
    check("release_no_step", saw, 0);
    check("release_count_held", cycleCount, cc0 + 16'd1);

    // Free run, with a press during RUN that must be ignored
    run = 1'b1;
    cc0 = 16'(m_cc);
    @(negedge clkIn);
    check("run_en_next", clkEnable, 1);
    check("run_running_next", running, 1);
    repeat (99) @(negedge clkIn);
    dlt = int'(cycleCount - cc0);
    check("run_edges_in_range", (dlt >= 12 && dlt <= 13), 1);
    key_step_n = 1'b0;
    repeat (40) @(negedge clkIn);
    key_step_n = 1'b1;
    repeat (30) @(negedge clkIn);
    run = 1'b0;
    @(negedge clkIn);
    check("run_stop_en", clkEnable, 0);
    check("run_stop_running", running, 0);
    saw = 0;
    repeat (30) begin @(negedge clkIn); if (clkEnable) saw = 1; end
    check("run_press_ignored", saw, 0);

    // run rises mid-step: step finishes, one HALT cycle, then RUN
    key_step_n = 1'b0;
    n = 0;
    while (!stepBusy && n < 40) begin @(negedge clkIn); n++; end
    check("step_run_busy", stepBusy, 1);
    run = 1'b1;
    n = 0;
    while (stepBusy && n < 12) begin @(negedge clkIn); n++; end
    check("step_run_halt_en", clkEnable, 0);
    check("step_run_halt_running", running, 0);
    check("step_run_halt_busy", stepBusy, 0);
    @(negedge clkIn);
    check("step_run_then_en", clkEnable, 1);
    check("step_run_then_running", running, 1);
    key_step_n = 1'b1;
    run = 1'b0;
    repeat (30) @(negedge clkIn);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clkIn);
      if ($urandom_range(19) == 0) run = ~run;
      if ($urandom_range(39) == 0) scan_en = ~scan_en;
      if ($urandom_range(9) == 0) regSel = 5'($urandom_range(31));
      if ($urandom_range(24) == 0) key_step_n = ~key_step_n;
    end

    // Reset in the middle of a run
    run = 1'b1; key_step_n = 1'b1; scan_en = 1'b0; regSel = 5'd7;
    repeat (40) @(negedge clkIn);
    #2 rst_n = 1'b0;
    #1;
    check("rstrun_clkEnable", clkEnable, 0);
    check("rstrun_running", running, 0);
    check("rstrun_regAddr", regAddr, 0);
    check("rstrun_cycleCount", cycleCount, 0);
    run = 1'b0;
    @(negedge clkIn);
    rst_n = 1'b1;
    repeat (3) @(negedge clkIn);

    // Reset in the middle of a step
    key_step_n = 1'b0;
    n = 0;
    while (!stepBusy && n < 40) begin @(negedge clkIn); n++; end
    check("rststep_busy_before", stepBusy, 1);
    key_step_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rststep_clkEnable", clkEnable, 0);
    check("rststep_stepBusy", stepBusy, 0);
    check("rststep_cycleCount", cycleCount, 0);
    @(negedge clkIn);
    rst_n = 1'b1;
    saw = 0;
    repeat (30) begin @(negedge clkIn); if (clkEnable) saw = 1; end
    check("rststep_stays_halted", saw, 0);
    check("rststep_no_edge", cycleCount, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
